// File: rtl/collision_pkg.sv
`default_nettype none
// ============================================================================
// Module   : collision_pkg
// Purpose  : Shared types and constants for the object bounce controller.
// Revision : 1.0 - initial release
// ============================================================================
package collision_pkg;

  // Per-frame controller phases
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EVAL    = 2'd1,
    ST_ISSUE   = 2'd2
  } coll_state_t;

  // Bit positions of the four frame borders in the side-flag vectors
  localparam int NUM_SIDES = 4;
  localparam int SIDE_L    = 0;
  localparam int SIDE_R    = 1;
  localparam int SIDE_T    = 2;
  localparam int SIDE_B    = 3;

  // X_direction encoding
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage
`default_nettype wire

// File: rtl/frame_holdoff_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_holdoff_counter
// Purpose  : Per-axis frame counter that blocks further bounces for a number
//            of frames after a bounce was accepted.
// Revision : 1.0 - initial release
// ============================================================================
module frame_holdoff_counter #(
  parameter int HOLDOFF_FRAMES = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic load,
  input  logic tick,
  output logic busy
);

  localparam int                 c_cnt_w = $clog2(HOLDOFF_FRAMES + 1);
  localparam logic [c_cnt_w-1:0] c_load  = c_cnt_w'(HOLDOFF_FRAMES);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_count;

  // Reload on an accepted bounce, otherwise count down once per tick and stop at zero
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_load;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - c_one;
    end
  end

  assign busy = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/object_collision_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : object_collision_ctrl
// Purpose  : Collects object/border overlaps during the raster scan and, at
//            each start of frame, turns them into X_direction / toggleY
//            commands, a collision pulse and a saturating hit count.
// Revision : 1.0 - initial release
// ============================================================================
module object_collision_ctrl
  import collision_pkg::*;
#(
  parameter int   HOLDOFF_FRAMES = 4,
  parameter logic INITIAL_X_DIR  = 1'b1,
  parameter int   CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 objectDR,
  input  logic                 leftDR,
  input  logic                 rightDR,
  input  logic                 topDR,
  input  logic                 bottomDR,
  input  logic                 toggleKey,
  output logic                 X_direction,
  output logic                 toggleY,
  output logic                 collision,
  output logic [CNT_WIDTH-1:0] hitCount
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  coll_state_t          r_state;
  logic [NUM_SIDES-1:0] r_hit;
  logic [NUM_SIDES-1:0] r_snap;
  logic                 r_key_d;
  logic                 r_key_pending;
  logic                 r_snap_key;

  logic [NUM_SIDES-1:0] w_hit_now;
  logic                 w_key_rise;
  logic                 w_frame_start;
  logic                 w_eval;
  logic                 w_x_busy;
  logic                 w_y_busy;
  logic                 w_x_acc;
  logic                 w_y_acc;
  logic                 w_any_acc;

  assign w_hit_now[SIDE_L] = objectDR & leftDR;
  assign w_hit_now[SIDE_R] = objectDR & rightDR;
  assign w_hit_now[SIDE_T] = objectDR & topDR;
  assign w_hit_now[SIDE_B] = objectDR & bottomDR;
  assign w_key_rise        = toggleKey & ~r_key_d;

  // startOfFrame only counts while collecting; frames are far longer than the eval/issue tail
  assign w_frame_start = (r_state == ST_COLLECT) && startOfFrame;
  assign w_eval        = (r_state == ST_EVAL);

  // An axis is accepted only when its snapshot shows a hit and its holdoff has expired
  assign w_x_acc   = w_eval & (r_snap[SIDE_L] | r_snap[SIDE_R]) & ~w_x_busy;
  assign w_y_acc   = w_eval & (r_snap[SIDE_T] | r_snap[SIDE_B]) & ~w_y_busy;
  assign w_any_acc = w_x_acc | w_y_acc;

  // Sticky hit/key collection; at frame start the flags move into the snapshot and
  // restart from whatever happens in that same cycle, so nothing is lost between frames
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit         <= '0;
      r_snap        <= '0;
      r_key_d       <= 1'b0;
      r_key_pending <= 1'b0;
      r_snap_key    <= 1'b0;
    end else begin
      r_key_d <= toggleKey;
      if (w_frame_start) begin
        r_snap        <= r_hit;
        r_snap_key    <= r_key_pending;
        r_hit         <= w_hit_now;
        r_key_pending <= w_key_rise;
      end else begin
        r_hit         <= r_hit | w_hit_now;
        r_key_pending <= r_key_pending | w_key_rise;
      end
    end
  end

  // Frame FSM; all command outputs are registered at the EVAL->ISSUE edge so they
  // are visible during the single ISSUE cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_COLLECT;
      X_direction <= INITIAL_X_DIR;
      toggleY     <= 1'b0;
      collision   <= 1'b0;
      hitCount    <= '0;
    end else begin
      toggleY   <= 1'b0;
      collision <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (startOfFrame) r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          // Hitting both side walls at once is a counted hit but leaves the direction alone
          if (w_x_acc) begin
            if (r_snap[SIDE_L] && !r_snap[SIDE_R]) begin
              X_direction <= DIR_POS;
            end else if (r_snap[SIDE_R] && !r_snap[SIDE_L]) begin
              X_direction <= DIR_NEG;
            end
          end
          // Border bounce and key press merge into one invert so Y never flips twice
          toggleY   <= w_y_acc | r_snap_key;
          collision <= w_any_acc;
          if (w_any_acc && (hitCount != c_cnt_max)) begin
            hitCount <= hitCount + c_cnt_one;
          end
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_state <= ST_COLLECT;
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  frame_holdoff_counter #(
    .HOLDOFF_FRAMES (HOLDOFF_FRAMES)
  ) u_x_holdoff (
    .clk    (clk),
    .resetN (resetN),
    .load   (w_x_acc),
    .tick   (w_eval & ~w_x_acc),
    .busy   (w_x_busy)
  );

  frame_holdoff_counter #(
    .HOLDOFF_FRAMES (HOLDOFF_FRAMES)
  ) u_y_holdoff (
    .clk    (clk),
    .resetN (resetN),
    .load   (w_y_acc),
    .tick   (w_eval & ~w_y_acc),
    .busy   (w_y_busy)
  );

endmodule
`default_nettype wire
